sram_axi_arbiter: RTL

Single-master bridge that arbitrates between the CPU's instruction-fetch and data-memory SRAM-like ports (req/addr_ok/data_ok) and drives one AXI3 master port toward the SoC interconnect. It sits between the fetch and memory stages and the AXI crossbar. It serialises one transaction at a time, giving the data port priority over fetch. It converts byte, halfword and word accesses into AXI size and strobe encodings.

---
 rtl/sram_axi_arbiter_if.sv | 62 ++++++
 rtl/sram_axi_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sram_axi_arbiter_if.sv
// sram_axi_arbiter_if: AXI3 master port bundle between the arbiter and the SoC interconnect
interface sram_axi_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: serialises fetch and data SRAM-like requests onto one AXI3 master, data first
module sram_axi_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               inst_req,
    input  logic [31:0]        inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [31:0]        inst_rdata,
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [1:0]         data_size,
    input  logic [31:0]        data_addr,
    input  logic [31:0]        data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [31:0]        data_rdata,
    sram_axi_arbiter_if.master axi
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

    state_t      state;
    logic        owner_data;
    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        aw_done;
    logic        w_done;
    logic        grant_data;
    logic        grant_inst;
    logic        r_hs;
    logic        b_hs;
    logic        aw_hs;
    logic        w_hs;
    logic [3:0]  strb_nxt;

    // Arbitration, handshakes and pass-through read data; everything is masked while reset is held
    always_comb begin
        grant_data   = cpu_rst_n && state == IDLE && data_req;
        grant_inst   = cpu_rst_n && state == IDLE && !data_req && inst_req;
        r_hs         = cpu_rst_n && state == RD_DATA && axi.rvalid;
        b_hs         = cpu_rst_n && state == WR_RESP && axi.bvalid;
        aw_hs        = awvalid_q && axi.awready;
        w_hs         = wvalid_q && axi.wready;
        strb_nxt     = data_size == 2'd0 ? 4'b0001 << data_addr[1:0] :
                       data_size == 2'd1 ? (data_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        inst_data_ok = r_hs && !owner_data;
        data_data_ok = (r_hs && owner_data) || b_hs;
        inst_rdata   = inst_data_ok ? axi.rdata : inst_rdata_q;
        data_rdata   = (r_hs && owner_data) ? axi.rdata : data_rdata_q;
    end

    assign axi.arid    = id_q;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awid    = id_q;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'd0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = DATA_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = strb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    // Transaction FSM: capture the granted request, drive AXI channels, return to IDLE on response
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state        <= IDLE;
            owner_data   <= 1'b0;
            id_q         <= 4'd0;
            addr_q       <= 32'd0;
            size_q       <= 2'd0;
            wdata_q      <= 32'd0;
            strb_q       <= 4'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data || grant_inst) begin
                        owner_data <= grant_data;
                        id_q       <= grant_data ? DATA_ID : INST_ID;
                        addr_q     <= grant_data ? data_addr : inst_addr;
                        size_q     <= grant_data ? data_size : 2'd2;
                        wdata_q    <= grant_data ? data_wdata : 32'd0;
                        strb_q     <= grant_data ? strb_nxt : 4'b1111;
                        if (grant_data && data_wr) begin
                            state     <= WR_ADDR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                        end else begin
                            state     <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        state    <= IDLE;
                        if (owner_data) data_rdata_q <= axi.rdata;
                        else inst_rdata_q <= axi.rdata;
                    end
                end
                WR_ADDR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
